// File: rtl/lut_layer_sequencer.sv
// Time-multiplexed evaluator for one layer of FAN_IN-input, 1-bit-output
// truth-table neurons. One neuron is evaluated per cycle from a latched input
// vector, and the packed result is presented once all neurons are done.
//
// Ports:
//   clk, rst               clock (rising edge); synchronous active-low reset
//   cfg_we/addr/tt/sel     per-neuron truth table and input-select map write
//   in_valid/in_ready/M0   input activation handshake
//   out_valid/out_ready/M1 output vector handshake
//   busy                   high while a vector is being evaluated or held
module lut_layer_sequencer #(
  parameter int unsigned IN_WIDTH    = 16,
  parameter int unsigned NUM_NEURONS = 8,
  parameter int unsigned FAN_IN      = 6,
  parameter int unsigned SEL_W       = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1,
  parameter int unsigned IDX_W       = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_we,
  input  logic [IDX_W-1:0]          cfg_addr,
  input  logic [(1<<FAN_IN)-1:0]    cfg_tt,
  input  logic [FAN_IN*SEL_W-1:0]   cfg_sel,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [IN_WIDTH-1:0]       M0,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NUM_NEURONS-1:0]    M1,
  output logic                      busy
);

  localparam int unsigned TtW  = 1 << FAN_IN;
  // Internal neuron counter is sized to the layer, independent of the config port width.
  localparam int unsigned CntW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                    state_q;
  logic [CntW-1:0]           idx_q;
  logic [IN_WIDTH-1:0]       in_reg_q;
  logic [NUM_NEURONS-1:0]    work_q;
  logic [NUM_NEURONS-1:0]    work_d;
  logic [NUM_NEURONS-1:0]    m1_q;
  logic                      out_valid_q;

  logic [TtW-1:0]            tt_q  [NUM_NEURONS];
  logic [FAN_IN*SEL_W-1:0]   sel_q [NUM_NEURONS];

  logic [TtW-1:0]            tt_row;
  logic [FAN_IN*SEL_W-1:0]   sel_row;
  logic [SEL_W-1:0]          sel_k;
  logic [FAN_IN-1:0]         lut_addr;
  logic                      lut_bit;
  logic                      cfg_ok;
  logic                      last_idx;

  // in_ready is gated by rst directly so it is low for the whole reset window.
  assign in_ready  = rst && (state_q == StIdle);
  assign out_valid = out_valid_q;
  assign M1        = m1_q;
  assign busy      = (state_q != StIdle);

  assign cfg_ok   = cfg_we && (state_q == StIdle) && (32'(cfg_addr) < NUM_NEURONS);
  assign last_idx = (idx_q == CntW'(NUM_NEURONS - 1));

  // LUT address gather for the current neuron; out-of-range selects read 0.
  always_comb begin
    tt_row   = tt_q[idx_q];
    sel_row  = sel_q[idx_q];
    sel_k    = '0;
    lut_addr = '0;
    for (int k = 0; k < FAN_IN; k++) begin
      sel_k = sel_row[k*SEL_W +: SEL_W];
      if (32'(sel_k) < IN_WIDTH) begin
        lut_addr[k] = in_reg_q[sel_k];
      end
    end
    lut_bit        = tt_row[lut_addr];
    work_d         = work_q;
    work_d[idx_q]  = lut_bit;
  end

  // Configuration storage; tt and sel of one neuron always update together.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned n = 0; n < NUM_NEURONS; n++) begin
        tt_q[n]  <= '0;
        sel_q[n] <= '0;
      end
    end else begin
      for (int unsigned n = 0; n < NUM_NEURONS; n++) begin
        if (cfg_ok && (32'(cfg_addr) == n)) begin
          tt_q[n]  <= cfg_tt;
          sel_q[n] <= cfg_sel;
        end
      end
    end
  end

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      in_reg_q    <= '0;
      work_q      <= '0;
      m1_q        <= '0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            in_reg_q <= M0;
            idx_q    <= '0;
            state_q  <= StRun;
          end
        end
        StRun: begin
          work_q <= work_d;
          if (last_idx) begin
            // Load includes the bit computed this cycle; M1 never shows partial results.
            m1_q        <= work_d;
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
